// File: rtl/decoder_pkg.sv
// Shared types and width helpers for the registered one-hot decoder.
// Pure declarations: no latency, no backpressure.
package decoder_pkg;

    typedef enum logic {S_IDLE, S_SWEEP} dec_state_t;

    function automatic int onehot_w(input int aw);
        return 2 ** aw;
    endfunction

    // Hold counter needs at least one bit even when HOLD == 1.
    function automatic int hold_w(input int h);
        return (h > 1) ? $clog2(h) : 1;
    endfunction

endpackage

// File: rtl/decoder_core.sv
// Combinational ADDR_W -> 2^ADDR_W one-hot decoder with enable; zero latency.
// No backpressure: output follows inputs continuously.
module decoder_core
    import decoder_pkg::*;
#(
    parameter int ADDR_W = 5
) (
    input  logic                        i_en,
    input  logic [ADDR_W-1:0]           i_addr,
    output logic [onehot_w(ADDR_W)-1:0] o_dec
);

    localparam int OUTS = onehot_w(ADDR_W);

    assign o_dec = i_en ? (OUTS'(1) << i_addr) : '0;

endmodule

// File: rtl/decoder_sweep_n.sv
// Registered one-hot decoder with direct and self-test sweep modes; 1-cycle latency.
// No backpressure: inputs are sampled every cycle, sweep ignores them until done.
module decoder_sweep_n
    import decoder_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int HOLD     = 1,
    parameter int ZERO_EN  = 0,
    parameter int ZERO_IDX = 31
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  sweep_start,
    output logic [2**ADDR_W-1:0]  out,
    output logic [ADDR_W-1:0]     idx,
    output logic                  out_valid,
    output logic                  busy,
    output logic                  sweep_done
);

    localparam int OUTS = onehot_w(ADDR_W);
    localparam int HW   = hold_w(HOLD);
    localparam logic [OUTS-1:0] ZMASK =
        (ZERO_EN != 0) ? ~(OUTS'(1) << ZERO_IDX) : {OUTS{1'b1}};

    dec_state_t        r_state, w_state_nxt;
    logic [ADDR_W-1:0] r_cnt, w_cnt_nxt;
    logic [HW-1:0]     r_hold, w_hold_nxt;
    logic [OUTS-1:0]   r_out, w_out_nxt;
    logic [ADDR_W-1:0] r_idx, w_idx_nxt;
    logic              r_valid, w_valid_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_done, w_done_nxt;

    logic              w_core_en;
    logic [ADDR_W-1:0] w_core_addr;
    logic [OUTS-1:0]   w_dec;
    logic              w_hold_end;
    logic              w_cnt_end;

    assign w_hold_end = (r_hold == HW'(HOLD - 1));
    assign w_cnt_end  = &r_cnt;

    // Single decoder shared by both modes; the sweep addresses the next index.
    always_comb begin
        w_core_en   = 1'b0;
        w_core_addr = r_cnt + 1'b1;
        if (r_state == S_IDLE) begin
            w_core_en   = sweep_start | en;
            w_core_addr = sweep_start ? '0 : addr;
        end else begin
            w_core_en   = w_hold_end & ~w_cnt_end;
        end
    end

    decoder_core #(.ADDR_W(ADDR_W)) u_core (
        .i_en   (w_core_en),
        .i_addr (w_core_addr),
        .o_dec  (w_dec)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (sweep_start)              w_state_nxt = S_SWEEP;
            S_SWEEP: if (w_hold_end && w_cnt_end)  w_state_nxt = S_IDLE;
            default:                               w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_hold_nxt  = r_hold;
        w_out_nxt   = r_out;
        w_idx_nxt   = r_idx;
        w_valid_nxt = r_valid;
        w_busy_nxt  = r_busy;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_out_nxt = w_dec & ZMASK;
                if (sweep_start) begin
                    w_cnt_nxt   = '0;
                    w_hold_nxt  = '0;
                    w_idx_nxt   = '0;
                    w_valid_nxt = 1'b1;
                    w_busy_nxt  = 1'b1;
                end else begin
                    if (en) w_idx_nxt = addr;
                    w_valid_nxt = en;
                    w_busy_nxt  = 1'b0;
                end
            end
            default: begin
                if (!w_hold_end) begin
                    w_hold_nxt = r_hold + 1'b1;
                end else if (w_cnt_end) begin
                    w_out_nxt   = '0;
                    w_valid_nxt = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt  = r_cnt + 1'b1;
                    w_hold_nxt = '0;
                    w_out_nxt  = w_dec & ZMASK;
                    w_idx_nxt  = r_cnt + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt   <= '0;
            r_hold  <= '0;
            r_out   <= '0;
            r_idx   <= '0;
            r_valid <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_hold  <= w_hold_nxt;
            r_out   <= w_out_nxt;
            r_idx   <= w_idx_nxt;
            r_valid <= w_valid_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
        end
    end

    assign out        = r_out;
    assign idx        = r_idx;
    assign out_valid  = r_valid;
    assign busy       = r_busy;
    assign sweep_done = r_done;

endmodule

// File: doc/decoder_sweep_n.md
# decoder_sweep_n

Parametrised, registered N-to-2^N one-hot decoder for register-file write-select and bank-select paths. It replaces the fixed-width combinational decoder trees with a single generic block. In direct mode it registers a one-hot decode of `addr` gated by `en`. A built-in sweep mode walks every output in turn, for bring-up and self-test of downstream registers. An optional hard-zero index keeps one output permanently low, for a zero register.

## Interface
- `ADDR_W`, 5: address width; `OUTS = 2**ADDR_W` is a derived localparam.
- `HOLD`, 1: cycles each index stays asserted during sweep; legal range is ≥1.
- `ZERO_EN`, 0: when 1, output `ZERO_IDX` is forced low in all modes.
- `ZERO_IDX`, 31: index of the hard-zero output; legal range is < OUTS.

- `clk`  in  1  single clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `en`  in  1  direct-mode decode enable.
- `addr`  in  ADDR_W  direct-mode index.
- `sweep_start`  in  1  request a full sweep; sampled only in IDLE.
- `out`  out  OUTS  registered one-hot (or all-zero) select.
- `idx`  out  ADDR_W  registered index that `out` currently represents.
- `out_valid`  out  1  registered; 1 when `out` reflects a decode, including a masked index.
- `busy`  out  1  registered; 1 while in SWEEP.
- `sweep_done`  out  1  one-cycle pulse after the last sweep index.

## Operation
- FSM states: S_IDLE and S_SWEEP.
- **S_IDLE, sweep_start=0, per edge:**
  - `out <= en ? onehot(addr) : 0`
  - `idx <= en ? addr : idx`
  - `out_valid <= en`
- **S_IDLE, sweep_start=1:**
  - Has priority over `en`.
  - Go to S_SWEEP with `cnt <= 0`, `hold <= 0`.
  - `out <= onehot(0)`, `idx <= 0`, `out_valid <= 1`, `busy <= 1`.
- **S_SWEEP:**
  - `en`, `addr` and `sweep_start` are ignored.
  - `hold` counts 0..HOLD-1; each index is held for exactly HOLD cycles.
  - When `hold == HOLD-1` and `cnt < OUTS-1`: `cnt++`, `hold <= 0`, `out <= onehot(cnt+1)`, `idx <= cnt+1`.
  - When `hold == HOLD-1` and `cnt == OUTS-1`: return to S_IDLE with `out <= 0`, `out_valid <= 0`, `busy <= 0`, `sweep_done <= 1`.
- `sweep_done` is otherwise 0. It falls at the next edge regardless of inputs.
- **Zero mask (ZERO_EN=1):**
  - Bit `ZERO_IDX` of `out` is always 0.
  - `idx` and `out_valid` still report the masked index, so a sweep keeps its full duration with all-zero `out` for that index.
- `out` has at most one bit set at all times.
- `cnt` is ADDR_W bits wide. It never wraps: the termination compare is made before any increment.
- `hold` is `$clog2(HOLD)` bits wide, minimum 1.

## Timing
- Reset values: `out`=0, `idx`=0, `out_valid`=0, `busy`=0, `sweep_done`=0, state S_IDLE, `cnt`=0, `hold`=0.
- Direct-mode latency: 1 cycle from `addr`/`en` to `out`.
- Sweep:
  - Start accepted at edge E0.
  - Index k is asserted on edges E0+k·HOLD through E0+(k+1)·HOLD-1.
  - `busy` is high for OUTS·HOLD cycles.
  - `sweep_done` is high for the one cycle after `busy` falls.
- Back-to-back: `sweep_start` held high during the `sweep_done` cycle starts a new sweep at that edge. The `sweep_done` cycle is S_IDLE.
- Reset asserted mid-sweep clears everything immediately and asynchronously. No `sweep_done` is produced. Operation resumes in S_IDLE at the first edge after deassertion.

## Structure
- Package `decoder_pkg`:
  - `typedef enum logic {S_IDLE, S_SWEEP} dec_state_t`.
  - A parametrised `onehot` function, or a localparam helper, for ADDR_W→OUTS.
- Sub-module `decoder_core`: a purely combinational parametrised `ADDR_W`→`OUTS` decoder with enable. It is instantiated once and shared by the direct and sweep paths through a mux on its address and enable.
- The top level holds the FSM, `cnt`/`hold` counters, zero mask and output registers.

## Test plan
- Reset, then ADDR_W=5, en=1, addr=19 → next cycle `out`=32'h0008_0000, `idx`=19, `out_valid`=1. Then en=0 → `out`=0 and `out_valid`=0, with `idx` still 19.
- Exhaustive direct: en=1, addr=0..31 one per cycle → `out` equals `1<<addr` one cycle later, exactly one bit set.
- ADDR_W=3, HOLD=2, pulse sweep_start:
  - `out` shows 01,01,02,02,04,04,…,80,80.
  - `busy` is high for 16 cycles.
  - Then `sweep_done`=1 for 1 cycle with `out`=0.
  - en/addr toggling during the sweep has no effect.
- ZERO_EN=1, ZERO_IDX=31:
  - en=1, addr=31 → `out`=0, `out_valid`=1, `idx`=31.
  - A full sweep still lasts 32·HOLD cycles.
- sweep_start and en=1 with addr=7 in the same cycle → sweep wins and `out`=onehot(0). sweep_start re-pulsed mid-sweep is ignored, and the length is unchanged.
- Reset asserted asynchronously at sweep index 3 → all outputs 0 without waiting for an edge and no `sweep_done`. A direct decode works on the first cycle after release.
